// File: rtl/i2s_pkg.sv
// Shared I2S frame geometry and the signed audio sample type used by the NCO,
// the mixer and the transmitter.
package i2s_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 64;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  // Slot positions 1..16 carry sample bits 15..0; position 0 is the I2S delay bit.
  function automatic logic slot_is_data(input logic [4:0] pos);
    return (pos >= 5'd1) && (pos <= 5'(SAMPLE_BITS));
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S clock generator: divides master_clk into BCLK, counts bit positions
// through the 64-bit frame and drives LRCLK plus the falling/frame-start strobes.
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int HALF_DIV = 2
) (
  input  logic       master_clk,
  input  logic       rst,
  output logic       bclk,
  output logic       lrclk,
  output logic [5:0] bit_cnt_next,
  output logic       fall_evt,
  output logic       frame_start
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             lrclk_reg;
  logic [5:0]       bit_cnt_reg;
  logic             terminal;

  assign terminal     = (div_cnt_reg == DIV_W'(HALF_DIV - 1));
  assign fall_evt     = terminal & bclk_reg;
  assign bit_cnt_next = bit_cnt_reg + 6'd1;
  assign frame_start  = fall_evt && (bit_cnt_reg == 6'(FRAME_BITS - 1));

  always_ff @(posedge master_clk) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b0;
      bit_cnt_reg <= 6'(FRAME_BITS - 1);
    end else if (terminal) begin
      div_cnt_reg <= '0;
      bclk_reg    <= ~bclk_reg;
      // Bit position and word select advance only on the BCLK falling edge.
      if (bclk_reg) begin
        bit_cnt_reg <= bit_cnt_next;
        lrclk_reg   <= bit_cnt_next[5];
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign bclk  = bclk_reg;
  assign lrclk = lrclk_reg;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: captures samples at frame start and shifts them MSB-first
// onto SDATA. Define I2S_STEREO_EN to add the sample_in_r right-channel port.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int HALF_DIV = 2
) (
  input  logic        master_clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
`ifdef I2S_STEREO_EN
  input  logic [15:0] sample_in_r,
`endif
  input  logic        tx_mute,
  output logic        sample_clk_en,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  logic [5:0] bit_cnt_next;
  logic       fall_evt;
  logic       frame_start;

  i2s_clock_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_clock_gen (
    .master_clk  (master_clk),
    .rst         (rst),
    .bclk        (i2s_bclk),
    .lrclk       (i2s_lrclk),
    .bit_cnt_next(bit_cnt_next),
    .fall_evt    (fall_evt),
    .frame_start (frame_start)
  );

  sample_t    left_reg;
  sample_t    right_reg;
  sample_t    shift_reg;
  sample_t    left_cap;
  sample_t    right_cap;
  sample_t    shift_src;
  logic       sdata_reg;
  logic       strobe_reg;
  logic [4:0] pos_next;

  assign pos_next = bit_cnt_next[4:0];

  always_comb begin
    left_cap = tx_mute ? '0 : sample_t'(sample_in);
`ifdef I2S_STEREO_EN
    right_cap = tx_mute ? '0 : sample_t'(sample_in_r);
`else
    right_cap = tx_mute ? '0 : sample_t'(sample_in);
`endif
    // The first data bit of a slot comes straight from the captured channel.
    shift_src = shift_reg;
    if (pos_next == 5'd1)
      shift_src = bit_cnt_next[5] ? right_reg : left_reg;
  end

  always_ff @(posedge master_clk) begin
    if (!rst) begin
      left_reg   <= '0;
      right_reg  <= '0;
      shift_reg  <= '0;
      sdata_reg  <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      strobe_reg <= frame_start;
      if (frame_start) begin
        left_reg  <= left_cap;
        right_reg <= right_cap;
      end
      if (fall_evt) begin
        if (slot_is_data(pos_next)) begin
          sdata_reg <= shift_src[SAMPLE_BITS-1];
          shift_reg <= {shift_src[SAMPLE_BITS-2:0], 1'b0};
        end else begin
          sdata_reg <= 1'b0;
        end
      end
    end
  end

  assign sample_clk_en = strobe_reg;
  assign i2s_sdata     = sdata_reg;

endmodule
